// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-organised unified memory responder with programmable wait states
// Accepts memRead/memWrite in IDLE, counts wait states, then completes with a one-cycle ready pulse.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    output logic [31:0] memData,
    output logic        ready,
    output logic        fault
);
    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [3:0]        waitCount;
    logic [IDX_W-1:0]  wordIdx;
    logic [31:0]       reqData;
    logic              reqRead;
    logic              reqWrite;
    logic              reqIllegal;
    logic              accept;
    logic              illegalNow;
    logic              commitWrite;

    logic [31:0] mem [DEPTH_WORDS];

    // Illegal requests keep normal timing but never touch the array or memData.
    assign illegalNow = (memRead && memWrite) ||
                        (addr[1:0] != 2'b00) ||
                        (addr[31:2] >= DEPTH_LIMIT);

    assign commitWrite = (state == S_RESPOND) && reqWrite && !reqIllegal && !reset;

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (memRead || memWrite) begin
                    accept    = 1'b1;
                    nextState = (WAIT_CYCLES == 0) ? S_RESPOND : S_WAIT;
                end
            end
            S_WAIT: begin
                if (waitCount <= 4'd1) begin
                    nextState = S_RESPOND;
                end
            end
            S_RESPOND: nextState = S_IDLE;
            default:   nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            waitCount  <= 4'd0;
            ready      <= 1'b0;
            fault      <= 1'b0;
            memData    <= 32'd0;
            reqRead    <= 1'b0;
            reqWrite   <= 1'b0;
            reqIllegal <= 1'b0;
            reqData    <= 32'd0;
            wordIdx    <= '0;
        end else begin
            state <= nextState;
            ready <= (state == S_RESPOND);
            if (accept) begin
                reqRead    <= memRead;
                reqWrite   <= memWrite;
                reqIllegal <= illegalNow;
                reqData    <= writeData;
                wordIdx    <= addr[IDX_W+1:2];
                waitCount  <= WAIT_LOAD;
                fault      <= 1'b0;
            end else if (state == S_WAIT) begin
                waitCount <= waitCount - 4'd1;
            end
            // The access lands on the edge that raises ready, so data and ready appear together.
            if (state == S_RESPOND) begin
                fault <= reqIllegal;
                if (reqRead && !reqIllegal) begin
                    memData <= mem[wordIdx];
                end
            end
        end
    end

    // The array has no reset so stored program/data survive a processor reset.
    always_ff @(posedge clk) begin
        if (commitWrite) begin
            mem[wordIdx] <= reqData;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with WAIT_CYCLES=1 and WAIT_CYCLES=0
// Expected responses are queued at request time and retired when ready pulses.
module tb_mem_responder;
    localparam int DEPTH = 256;
    localparam int W1    = 1;
    localparam int W0    = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, rst0;
    logic [31:0] addr1, addr0, wdata1, wdata0;
    logic        rd1, rd0, wr1, wr0;
    logic [31:0] memData1, memData0;
    logic        ready1, ready0, fault1, fault0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t        q1[$];
    exp_t        q0[$];
    exp_t        e1, e0;
    logic [31:0] model1 [DEPTH];
    logic [31:0] model0 [DEPTH];
    logic [31:0] last1 = 32'd0;
    logic [31:0] last0 = 32'd0;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(rst1), .addr(addr1), .writeData(wdata1),
        .memRead(rd1), .memWrite(wr1), .memData(memData1), .ready(ready1), .fault(fault1)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(rst0), .addr(addr0), .writeData(wdata0),
        .memRead(rd0), .memWrite(wr0), .memData(memData0), .ready(ready0), .fault(fault0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready1) begin
            if (q1.size() == 0) begin
                check("spurious_ready1", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("data1", memData1, e1.data);
                check("fault1", {31'd0, fault1}, {31'd0, e1.fault});
                check("latency1", cyc, e1.due);
            end
        end
        if (ready0) begin
            if (q0.size() == 0) begin
                check("spurious_ready0", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("data0", memData0, e0.data);
                check("fault0", {31'd0, fault0}, {31'd0, e0.fault});
                check("latency0", cyc, e0.due);
            end
        end
    end

    function automatic int qsize(input int sel);
        return (sel == 1) ? q1.size() : q0.size();
    endfunction

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel == 1) begin
            rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd;
        end else begin
            rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd;
        end
    endtask

    task automatic pushExp(input int sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd, input int due);
        exp_t        e;
        logic [29:0] w;
        logic        bad;
        int          idx;
        w   = a[31:2];
        bad = (rd && wr) || (a[1:0] != 2'b00) || (w >= 30'(DEPTH));
        idx = bad ? 0 : int'(w);
        if (sel == 1) begin
            if (!bad && wr) model1[idx] = wd;
            if (!bad && rd) last1 = model1[idx];
            e = '{last1, bad, due};
            q1.push_back(e);
        end else begin
            if (!bad && wr) model0[idx] = wd;
            if (!bad && rd) last0 = model0[idx];
            e = '{last0, bad, due};
            q0.push_back(e);
        end
    endtask

    task automatic waitIdle(input int sel);
        int n = 0;
        while (qsize(sel) != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (qsize(sel) != 0) begin
            check("resp_timeout", 32'd0, 32'd1);
            if (sel == 1) q1.delete(); else q0.delete();
        end
    endtask

    // Caller is #1 after an edge with the DUT idle; acceptance happens on the next edge.
    task automatic request(input int sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd);
        drive(sel, rd, wr, a, wd);
        pushExp(sel, rd, wr, a, wd, cyc + 1 + ((sel == 1) ? W1 : W0) + 1);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, a, wd);
        waitIdle(sel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst1 = 1'b1; rst0 = 1'b1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready1", {31'd0, ready1}, 32'd0);
        check("rst_fault1", {31'd0, fault1}, 32'd0);
        check("rst_data1", memData1, 32'd0);
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        rst1 = 1'b0; rst0 = 1'b0;
        @(posedge clk); #1;

        request(1, 1'b0, 1'b1, 32'h0000_0000, 32'h8C01_0004);
        request(1, 1'b1, 1'b0, 32'h0000_0000, 32'd0);
        request(1, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        request(1, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
        request(1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
        request(1, 1'b0, 1'b1, 32'h0000_0014, 32'h0000_0055);
        request(1, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);

        request(1, 1'b1, 1'b0, 32'h0000_0012, 32'd0);
        request(1, 1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111);
        request(1, 1'b1, 1'b0, DEPTH * 4, 32'd0);
        request(1, 1'b0, 1'b1, 32'h0000_0011, 32'h2222_2222);
        request(1, 1'b0, 1'b1, DEPTH * 4 + 4, 32'h3333_3333);
        request(1, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
        request(1, 1'b1, 1'b0, 32'h0000_0010, 32'd0);

        // Address and strobe changes while busy must not disturb the latched request.
        drive(1, 1'b1, 1'b0, 32'h0000_0000, 32'd0);
        pushExp(1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, cyc + 1 + W1 + 1);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0000_0040, 32'd0);
        waitIdle(1);

        drive(1, 1'b0, 1'b1, 32'h0000_0014, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0000_0014, 32'hAAAA_AAAA);
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        last1 = 32'd0;
        check("abort_ready", {31'd0, ready1}, 32'd0);
        check("abort_data", memData1, 32'd0);
        check("abort_fault", {31'd0, fault1}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        request(1, 1'b1, 1'b0, 32'h0000_0014, 32'd0);
        request(1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);

        request(0, 1'b0, 1'b1, 32'h0000_0000, 32'hA0A0_A0A0);
        request(0, 1'b0, 1'b1, 32'h0000_0004, 32'hB1B1_B1B1);
        drive(0, 1'b1, 1'b0, 32'h0000_0000, 32'd0);
        pushExp(0, 1'b1, 1'b0, 32'h0000_0000, 32'd0, cyc + 1 + W0 + 1);
        pushExp(0, 1'b1, 1'b0, 32'h0000_0004, 32'd0, cyc + 3 + W0 + 1);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h0000_0004, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0000_0004, 32'd0);
        waitIdle(0);
        request(0, 1'b1, 1'b0, DEPTH * 4, 32'd0);
        request(0, 1'b1, 1'b0, 32'h0000_0000, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("queues_empty", 32'(q1.size() + q0.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
